// File: rtl/matrix_row_reader.sv
// Matrix row reader: fetches one row at a time from the matrix row port
// and streams its elements out with valid/ready, tagged with row/column.
module matrix_row_reader #(
  parameter int NUM_ROWS = 11,
  parameter int NUM_COLS = 4,
  parameter int WIDTH    = 32,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      finished,
  output logic [RW-1:0]             mat_row_addr,
  output logic                      mat_row_addr_ready,
  input  logic                      mat_row_valid,
  input  logic [NUM_COLS*WIDTH-1:0] mat_row_out,
  output logic [WIDTH-1:0]          out_data,
  output logic [RW-1:0]             out_row,
  output logic [CW-1:0]             out_col,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

  logic [2:0]                state;
  logic [RW-1:0]             row;
  logic [CW-1:0]             col;
  logic [NUM_COLS*WIDTH-1:0] row_buf;

  logic row_end;
  logic mat_end;

  assign row_end = (col == LAST_COL);
  assign mat_end = row_end && (row == LAST_ROW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      row_buf <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= REQ;
            row   <= '0;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (mat_row_valid) begin
            row_buf <= mat_row_out;
            col     <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (!row_end) begin
              col <= col + 1'b1;
            end else if (!mat_end) begin
              col   <= '0;
              row   <= row + 1'b1;
              state <= REQ;
            end else begin
              col   <= '0;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the registered state and counters,
  // so they are stable for the whole cycle and zero after reset.
  assign busy               = (state == REQ) || (state == WAIT) ||
                              (state == STREAM);
  assign finished           = (state == DONE);
  assign mat_row_addr       = row;
  assign mat_row_addr_ready = (state == REQ);
  assign out_valid          = (state == STREAM);
  assign out_last           = (state == STREAM) && mat_end;
  assign out_row            = row;
  assign out_col            = col;
  assign out_data           = row_buf[int'(col)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_matrix_row_reader.sv
// Bench for matrix_row_reader: matrix model with variable latency,
// element scoreboard, stall/noise/reset corners and a 1x1 instance.
module tb_matrix_row_reader;
  localparam int NR = 11;
  localparam int NC = 4;
  localparam int W  = 32;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  r;
    logic [1:0]  c;
    logic        l;
  } el_t;

  typedef struct {
    int lat;
    bit tog;
    bit noise;
    int exp_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start_t, nstart, start;
  logic busy, finished, mat_row_addr_ready, mat_row_valid;
  logic [3:0] mat_row_addr, out_row;
  logic [1:0] out_col;
  logic [NC*W-1:0] mat_row_out;
  logic [W-1:0] out_data;
  logic out_last, out_valid, out_ready;

  logic s1, b1, f1, ar1, v1, l1, ov1, rdy1;
  logic [0:0] a1, or1, oc1;
  logic [W-1:0] d1, od1;

  int checks = 0;
  int failures = 0;
  int reqs, fins, k;
  int lat;
  bit tog, noise;
  int cnt;
  logic [3:0] raddr;
  logic spur;
  el_t q[$];

  always #5 clk = ~clk;
  assign start = start_t | nstart;

  matrix_row_reader #(.NUM_ROWS(NR), .NUM_COLS(NC), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .finished(finished), .mat_row_addr(mat_row_addr),
    .mat_row_addr_ready(mat_row_addr_ready),
    .mat_row_valid(mat_row_valid), .mat_row_out(mat_row_out),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  matrix_row_reader #(.NUM_ROWS(1), .NUM_COLS(1), .WIDTH(W)) u1 (
    .clk(clk), .rst(rst), .start(s1), .busy(b1), .finished(f1),
    .mat_row_addr(a1), .mat_row_addr_ready(ar1),
    .mat_row_valid(v1), .mat_row_out(d1), .out_data(od1),
    .out_row(or1), .out_col(oc1), .out_last(l1), .out_valid(ov1),
    .out_ready(rdy1)
  );

  function automatic logic [31:0] f2b(int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 31; i++) if ((v >> i) != 0) e = i;
    m = (v << (23 - e)) & 32'h7FFFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Matrix model: row data appears lat cycles after the request.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (mat_row_addr_ready) begin
      cnt   <= lat;
      raddr <= mat_row_addr;
    end else if (cnt > 0) cnt <= cnt - 1;
  end

  assign mat_row_valid = (cnt == 1) | spur;

  always_comb begin
    mat_row_out = '1;
    if (cnt == 1)
      for (int c = 0; c < NC; c++)
        mat_row_out[c*W +: W] = f2b(int'(raddr) * NC + c);
  end

  // Ready pattern 1,0,0,1 plus noise: spurious valid and busy starts.
  always @(posedge clk) begin
    #1;
    out_ready = !tog || (k % 4 == 0) || (k % 4 == 3);
    spur   = noise && (k % 5 == 0) && (out_valid || !busy);
    nstart = noise && busy && (k % 9 == 0);
    k++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mat_row_addr_ready) reqs++;
      if (finished) fins++;
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_elem: got r%0d c%0d expected none",
                   out_row, out_col);
        end else begin
          chk(out_ready ? "elem" : "stall_hold",
              64'({out_data, out_row, out_col, out_last}),
              64'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic push_all();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        q.push_back('{f2b(r * NC + c), 4'(r), 2'(c),
                      (r == NR - 1) && (c == NC - 1)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_t = 1'b1;
    @(posedge clk); #1 start_t = 1'b0;
  endtask

  task automatic run(input vec_t v, output int n);
    bit seen;
    lat = v.lat; tog = v.tog; noise = v.noise;
    reqs = 0; fins = 0; n = 0; seen = 0;
    push_all();
    pulse_start();
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (finished) seen = 1;
    end
    chk("finished_seen", 64'(seen), 64'd1);
    if (noise && seen) begin
      start_t = 1'b1;
      @(posedge clk); #1 start_t = 1'b0;
    end
    noise = 0;
    repeat (4) @(negedge clk);
    if (v.exp_cyc > 0) chk("cycles", 64'(n), 64'(v.exp_cyc));
    chk("left_in_queue", 64'(q.size()), 64'd0);
    chk("requests", 64'(reqs), 64'(NR));
    chk("finished_count", 64'(fins), 64'd1);
    chk("idle_after", 64'({busy, out_valid, mat_row_addr_ready}), 64'd0);
    q.delete();
  endtask

  task automatic chk_zero(input string n);
    chk(n, 64'({busy, finished, mat_row_addr_ready, out_valid, out_last,
                mat_row_addr, out_row, out_col}), 64'd0);
    chk({n, "_data"}, 64'(out_data), 64'd0);
  endtask

  vec_t tv[4];
  int cyc[4];
  bit hit;

  initial begin
    tv[0] = '{1, 0, 0, 67};
    tv[1] = '{5, 0, 0, 111};
    tv[2] = '{1, 1, 0, -1};
    tv[3] = '{2, 1, 1, -1};
    rst = 1'b1; start_t = 0; nstart = 0; spur = 0; out_ready = 1;
    lat = 1; tog = 0; noise = 0; k = 0; reqs = 0; fins = 0;
    s1 = 0; v1 = 0; d1 = '0; rdy1 = 1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run(tv[i], cyc[i]);
    chk("latency_delta", 64'(cyc[1] - cyc[0]), 64'(NR * NC));

    // Reset while streaming row 5, column 2.
    lat = 1; tog = 0;
    push_all();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (out_valid && out_row == 4'd5 && out_col == 2'd2) hit = 1;
    end
    chk("reach_r5c2", 64'(hit), 64'd1);
    rst = 1'b1;
    #1 chk_zero("mid_reset");
    q.delete();
    repeat (2) @(negedge clk);
    chk_zero("reset_held");
    rst = 1'b0;
    run(tv[0], cyc[0]);

    // 1x1 instance.
    @(posedge clk); #1 s1 = 1'b1;
    @(posedge clk); #1 s1 = 1'b0;
    chk("u1_req", 64'({ar1, b1}), 64'b11);
    @(posedge clk); #1 v1 = 1'b1; d1 = 32'h3F800000;
    @(posedge clk); #1 v1 = 1'b0; d1 = '0;
    chk("u1_elem", 64'({ov1, od1, or1, oc1, l1}),
        64'({1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b1}));
    @(posedge clk); #1;
    chk("u1_finished", 64'({f1, b1, ov1}), 64'b100);
    @(posedge clk); #1;
    chk("u1_finish_once", 64'({f1, b1, ar1}), 64'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
